// File: rtl/quad_dir_decoder.sv
// Quadrature A/B front end: synchronises and glitch-filters both channels, then
// emits a one-cycle step strobe with direction, or an error pulse on a double-bit jump.
module quad_dir_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  // state  | meaning
  // INIT   | wait for sync chain and filters to settle, then capture prev
  // TRACK  | classify every filtered A/B change against prev

  localparam int FILT_W     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SETTLE_LEN = SYNC_STAGES + FILT_LEN;
  localparam int SETTLE_W   = $clog2(SETTLE_LEN + 1);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t                    state, state_nxt;
  logic [SYNC_STAGES-1:0]    sync_a, sync_b;
  logic [1:0]                s_ab, f_ab, prev_ab, prev_nxt;
  logic [1:0][FILT_W-1:0]    filt_cnt;
  logic [SETTLE_W-1:0]       settle_cnt, settle_nxt;
  logic                      step_nxt, err_nxt, dir_nxt;
  logic [ERR_W-1:0]          err_count_nxt;

  assign s_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      f_ab     <= '0;
      filt_cnt <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
      // a channel only moves after FILT_LEN consecutive samples disagree with it
      for (int i = 0; i < 2; i++) begin
        if (s_ab[i] == f_ab[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_W'(FILT_LEN - 1)) begin
          f_ab[i]     <= s_ab[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      settle_cnt <= '0;
      prev_ab    <= '0;
      step       <= 1'b0;
      up_down    <= 1'b1;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      prev_ab    <= prev_nxt;
      step       <= step_nxt;
      up_down    <= dir_nxt;
      err        <= err_nxt;
      err_count  <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_INIT: begin
        if (settle_cnt == SETTLE_W'(SETTLE_LEN)) begin
          state_nxt = ST_TRACK;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      ST_TRACK: state_nxt = ST_TRACK;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    step_nxt      = 1'b0;
    err_nxt       = 1'b0;
    dir_nxt       = up_down;
    prev_nxt      = prev_ab;
    err_count_nxt = err_count;
    if (state == ST_TRACK) begin
      prev_nxt = f_ab;
      case ({prev_ab, f_ab})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          step_nxt = 1'b1;
          dir_nxt  = 1'b1;
        end
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          step_nxt = 1'b1;
          dir_nxt  = 1'b0;
        end
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: err_nxt = 1'b1;
        default: ;
      endcase
    end else if (settle_cnt == SETTLE_W'(SETTLE_LEN)) begin
      // capture whatever level the pins settled to so a held pin never counts
      prev_nxt = f_ab;
    end
    if (err_clr) begin
      err_count_nxt = '0;
    end else if (err_nxt && !(&err_count)) begin
      err_count_nxt = err_count + 1'b1;
    end
  end

endmodule
